// File: rtl/road_sign_pkg.sv
// road_sign_pkg: mode encodings and helpers shared by the road-sign control and pattern blocks
package road_sign_pkg;
  localparam int MODE_W = 2;
  typedef enum logic [MODE_W-1:0] {
    MODE_OFF   = 2'd0,
    MODE_WARN  = 2'd1,
    MODE_LEFT  = 2'd2,
    MODE_RIGHT = 2'd3
  } mode_t;
  function automatic logic [3:0] mode_onehot(mode_t m);
    return 4'b0001 << m;
  endfunction
endpackage

// File: rtl/sign_mode_ctrl_if.sv
// sign_mode_ctrl_if: button/switch inputs and mode/tick outputs of the sign mode controller
interface sign_mode_ctrl_if;
  import road_sign_pkg::*;
  logic       btn;
  logic [1:0] sw_speed;
  mode_t      mode;
  logic [3:0] mode_en;
  logic       tick;
  logic       mode_rst;
  modport master (output btn, sw_speed, input mode, mode_en, tick, mode_rst);
  modport slave  (input btn, sw_speed, output mode, mode_en, tick, mode_rst);
endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchroniser, stability counter and rising-edge press detector
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 1_250_000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYC) + 1;
  logic [1:0]    sync;
  logic          stable_q;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk)
    if (reset) begin
      sync     <= '0;
      stable   <= 1'b0;
      stable_q <= 1'b0;
      cnt      <= '0;
    end else begin
      sync     <= {sync[0], raw};
      stable_q <= stable;
      if (sync[1] == stable) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
        stable <= sync[1];
        cnt    <= '0;
      end else cnt <= cnt + CW'(1);
    end
  assign press = stable & ~stable_q;
endmodule

// File: rtl/sign_mode_ctrl.sv
// sign_mode_ctrl: debounced mode stepping, rate tick and restart pulse; SIGN_LONG_PRESS_EN adds long-press to OFF
module sign_mode_ctrl
  import road_sign_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1_250_000,
  parameter int TICK_BASE    = 62_500_000,
  parameter int LONG_CYC     = 250_000_000
) (
  input logic             clk,
  input logic             reset,
  sign_mode_ctrl_if.slave bus
);
  localparam int TW = $clog2(TICK_BASE + 1);
  logic          stable, press, long_fire, chg;
  logic [1:0]    sw_s1, sw_s2;
  logic [TW-1:0] cnt, period;
  mode_t         mode_d;
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn (
    .clk(clk), .reset(reset), .raw(bus.btn), .stable(stable), .press(press)
  );
`ifdef SIGN_LONG_PRESS_EN
  localparam int HW = $clog2(LONG_CYC) + 1;
  logic [HW-1:0] hold;
  always_ff @(posedge clk)
    if (reset || !stable) hold <= '0;
    else if (hold != HW'(LONG_CYC - 1)) hold <= hold + HW'(1);
  // fires on the edge where the saturating hold count reaches LONG_CYC-1
  assign long_fire = stable && hold == HW'(LONG_CYC - 2);
`else
  logic unused_stable;
  assign unused_stable = stable;
  assign long_fire     = 1'b0;
`endif
  always_comb begin
    mode_d = press ? mode_t'(bus.mode + 2'd1) : (long_fire ? MODE_OFF : bus.mode);
    chg    = press | (long_fire & (bus.mode != MODE_OFF));
    period = TW'(TICK_BASE) >> sw_s2;
  end
  always_ff @(posedge clk)
    if (reset) begin
      sw_s1        <= '0;
      sw_s2        <= '0;
      bus.mode     <= MODE_OFF;
      bus.mode_en  <= 4'b0001;
      bus.mode_rst <= 1'b0;
      bus.tick     <= 1'b0;
      cnt          <= '0;
    end else begin
      sw_s1        <= bus.sw_speed;
      sw_s2        <= sw_s1;
      bus.mode     <= mode_d;
      bus.mode_en  <= mode_onehot(mode_d);
      bus.mode_rst <= chg;
      // a mode change restarts the pattern period even on a terminal count
      if (chg || bus.mode == MODE_OFF) begin
        cnt      <= '0;
        bus.tick <= 1'b0;
      end else if (cnt >= period - TW'(1)) begin
        cnt      <= '0;
        bus.tick <= 1'b1;
      end else begin
        cnt      <= cnt + TW'(1);
        bus.tick <= 1'b0;
      end
    end
endmodule

// File: tb/tb_sign_mode_ctrl.sv
// tb_sign_mode_ctrl: directed stimulus with a behavioural reference model checked every cycle
module tb_sign_mode_ctrl;
  import road_sign_pkg::*;
  localparam int D = 4, TB = 16, L = 32;
`ifdef SIGN_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  sign_mode_ctrl_if bus();
  sign_mode_ctrl #(.DEBOUNCE_CYC(D), .TICK_BASE(TB), .LONG_CYC(L)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  int passed = 0, total = 0;
  bit m_valid = 1'b0;
  int b1, b2, w1, w2, stable, stable_q, disagree, m_mode, m_rst, m_tick, elapsed, held;
  task automatic check(string name, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
  endtask
  // Reference: button seen 2 edges late, accepted after D disagreeing edges, mode steps on
  // accepted rise, tick after P elapsed cycles since restart or previous tick.
  task automatic model_step();
    bit pr, fire, was_off, changed;
    int p, held_new;
    if (reset) begin
      {b1, b2, w1, w2, stable, stable_q, disagree} = '0;
      {m_mode, m_rst, m_tick, elapsed, held} = '0;
      m_valid = 1'b1;
      return;
    end
    pr       = stable == 1 && stable_q == 0;
    held_new = stable == 1 ? ((held + 1 > L - 1) ? L - 1 : held + 1) : 0;
    fire     = LONG_EN && held_new == L - 1 && held < L - 1;
    held     = held_new;
    p        = TB >> w2;
    was_off  = m_mode == 0;
    changed  = pr || (fire && !was_off);
    if (pr) m_mode = (m_mode + 1) % 4;
    else if (fire) m_mode = 0;
    m_rst = changed;
    if (changed || was_off) begin
      m_tick  = 0;
      elapsed = 0;
    end else begin
      elapsed++;
      m_tick = elapsed >= p;
      if (m_tick == 1) elapsed = 0;
    end
    stable_q = stable;
    if (b2 == stable) disagree = 0;
    else begin
      disagree++;
      if (disagree == D) begin
        stable   = b2;
        disagree = 0;
      end
    end
    b2 = b1; b1 = int'(bus.btn);
    w2 = w1; w1 = int'(bus.sw_speed);
  endtask
  initial forever begin
    @(posedge clk);
    model_step();
  end
  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      check("mode", int'(bus.mode), m_mode);
      check("mode_en", int'(bus.mode_en), 1 << m_mode);
      check("tick", int'(bus.tick), m_tick);
      check("mode_rst", int'(bus.mode_rst), m_rst);
    end
  end
  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic press(bit keep);
    bus.btn = 1'b1;
    cyc(7);
    if (!keep) bus.btn = 1'b0;
  endtask
  initial begin
    int exp_mode[4] = '{2, 3, 0, 1};
    int exp_en[4]   = '{4, 8, 1, 2};
    int n;
    bus.btn = 1'b0;
    bus.sw_speed = 2'd0;
    cyc(2);
    reset = 1'b0;
    check("rst_mode", int'(bus.mode), 0);
    check("rst_en", int'(bus.mode_en), 1);
    check("rst_tick", int'(bus.tick), 0);
    check("rst_mrst", int'(bus.mode_rst), 0);
    for (int i = 0; i < 6; i++) begin
      bus.btn = ~bus.btn;
      cyc(2);
    end
    bus.btn = 1'b1;
    cyc(6);
    check("bounce_e6_mode", int'(bus.mode), 0);
    check("bounce_e6_mrst", int'(bus.mode_rst), 0);
    cyc(1);
    check("bounce_e7_mode", int'(bus.mode), 1);
    check("bounce_e7_en", int'(bus.mode_en), 2);
    check("bounce_e7_mrst", int'(bus.mode_rst), 1);
    for (int k = 1; k <= 48; k++) begin
      cyc(1);
      if (k == 13) bus.btn = 1'b0;
      check("warn_tick", int'(bus.tick), (k % 16 == 0) ? 1 : 0);
      check("warn_mode", int'(bus.mode), 1);
    end
    bus.sw_speed = 2'd2;
    cyc(4);
    check("fast_first", int'(bus.tick), 1);
    n = 0;
    for (int k = 0; k < 16; k++) begin
      cyc(1);
      n += int'(bus.tick);
    end
    check("fast_count", n, 4);
    bus.sw_speed = 2'd0;
    cyc(3);
    for (int i = 0; i < 4; i++) begin
      press(1'b0);
      check("step_mode", int'(bus.mode), exp_mode[i]);
      check("step_en", int'(bus.mode_en), exp_en[i]);
      check("step_mrst", int'(bus.mode_rst), 1);
      if (i < 3)
        for (int k = 0; k < 10; k++) begin
          cyc(1);
          if (exp_mode[i] == 0) check("off_tick", int'(bus.tick), 0);
        end
    end
    cyc(25);
    press(1'b1);
    check("coinc_mode", int'(bus.mode), 2);
    check("coinc_mrst", int'(bus.mode_rst), 1);
    check("coinc_tick", int'(bus.tick), 0);
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      cyc(1);
      n += int'(bus.mode_rst);
      if (k <= 16) check("coinc_next_tick", int'(bus.tick), (k == 16) ? 1 : 0);
    end
    check("hold_mode", int'(bus.mode), LONG_EN ? 0 : 2);
    check("hold_pulses", n, LONG_EN ? 1 : 0);
    bus.btn = 1'b0;
    cyc(10);
    repeat (LONG_EN ? 3 : 1) begin
      press(1'b0);
      cyc(10);
    end
    cyc(20);
    check("right_mode", int'(bus.mode), 3);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    check("mid_rst_mode", int'(bus.mode), 0);
    check("mid_rst_en", int'(bus.mode_en), 1);
    check("mid_rst_tick", int'(bus.tick), 0);
    check("mid_rst_mrst", int'(bus.mode_rst), 0);
    for (int k = 0; k < 40; k++) begin
      cyc(1);
      check("post_rst_tick", int'(bus.tick), 0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/sign_mode_ctrl.md
Name: sign_mode_ctrl

Overview:
- Upstream control stage for the road-sign pattern FSMs (warning, arrow-left, arrow-right) on PYNQ Z1.
- Debounces the user push-button and steps through sign modes.
- Produces a one-hot per-mode enable, a one-cycle pattern tick at a switch-selectable rate, and a one-cycle pattern-restart pulse on every mode change.
- Downstream FSMs consume `enable` (one bit of `mode_en`), `tick` and `reset` (`reset | mode_rst`).

Parameters:
- DEBOUNCE_CYC, 1_250_000, cycles the synchronised button must stay stable before acceptance (10 ms at 125 MHz).
- TICK_BASE, 62_500_000, tick period in cycles at `sw_speed`=0 (0.5 s). Must be ≥ 8.
- LONG_CYC, 250_000_000, hold time for long-press return to OFF (used only with the optional feature).

Ports:
- clk  in  1  system clock, 125 MHz
- reset  in  1  synchronous, active-high
- btn  in  1  raw asynchronous push-button, active-high, bouncy
- sw_speed  in  2  asynchronous rate select; period P = TICK_BASE >> sw_speed
- mode  out  2  current mode: 0 OFF, 1 WARN, 2 LEFT, 3 RIGHT
- mode_en  out  4  one-hot of `mode`; bit0 = OFF
- tick  out  1  one-cycle pattern-advance pulse, registered
- mode_rst  out  1  one-cycle pulse, high in the first cycle of a new mode, registered

Behaviour:
- Reset (one cycle, wins over everything): `mode`=0, `mode_en`=4'b0001, `tick`=0, `mode_rst`=0; all counters, synchronisers and debounced state cleared to 0.
- Synchronisation: `btn` and `sw_speed` each pass through a 2-flop synchroniser.
- Debounce:
  - Counter clears whenever the synchronised button equals the stable level.
  - Otherwise the counter increments. At DEBOUNCE_CYC-1 the stable level takes the synchronised value and the counter clears.
  - Any disagreement-free cycle restarts the count.
- Press detection: `press` = stable & ~stable_q (combinational, rising edge only).
- Latency: on a clean rise, `mode`/`mode_rst` update on rising edge DEBOUNCE_CYC+3, counting the first edge that samples `btn` high as edge 1.
- Mode FSM: on `press`, OFF→WARN→LEFT→RIGHT→OFF (wrap). `mode_rst`<=1 in the same update; otherwise `mode_rst`<=0. `mode_en` is registered alongside `mode`.
- Tick prescaler:
  - In OFF: counter held at 0, `tick`=0.
  - Otherwise, if cnt ≥ P-1: `tick`<=1 and cnt<=0. Else `tick`<=0 and cnt<=cnt+1.
  - The ≥ comparison means that switching to a shorter P with cnt already past it gives a tick on the next edge.
- Mode change restarts timing: on `press`, cnt<=0 and `tick`<=0, even if the terminal count coincides with the press.
  - First tick of the new mode is P cycles after the `mode_rst` cycle. Ticks are then strictly periodic with period P.
- Release does nothing. A held button gives exactly one step.

Optional Feature:
- Macro: SIGN_LONG_PRESS_EN.
- Defined:
  - A hold counter runs while stable=1 and clears on release.
  - On reaching LONG_CYC-1: `mode`<=OFF and `mode_rst`<=1 (pulse suppressed if already OFF). Hold counter saturates, so this fires once per hold.
- Undefined: no hold counter; holding has no effect beyond the initial step.

Decomposition:
- Package `road_sign_pkg`:
  - Mode encodings MODE_OFF/WARN/LEFT/RIGHT
  - Mode width constant
  - Function mode→one-hot
- Sub-module `btn_debounce` (clk, reset, raw in → stable, press): synchroniser, debounce counter and edge detector, reusable for future buttons.

Test Plan (DEBOUNCE_CYC=4, TICK_BASE=16, LONG_CYC=32):
- Reset asserted mid-RIGHT with ticks running → next edge `mode`=0, `mode_en`=0001, `tick`=0, `mode_rst`=0; no tick for 40 cycles.
- `btn` toggles every 2 cycles for 12 cycles, then held high 20 cycles → exactly one step OFF→WARN, `mode_rst` high exactly 1 cycle, at edge 7 after the final rise.
- WARN, `sw_speed`=0 → `tick` at cycles 16, 32, 48 after `mode_rst`. Switch to `sw_speed`=2 → ticks every 4 cycles once the synchroniser settles.
- Four clean presses → `mode` 1,2,3,0 with `mode_en` 0010, 0100, 1000, 0001; `tick` never high while OFF.
- Press whose update coincides with cnt=15 → no tick that cycle; next tick 16 cycles after `mode_rst`.
- SIGN_LONG_PRESS_EN, hold in LEFT for 40 cycles → `mode` returns to 0 once, with a single `mode_rst` pulse. Without the macro → `mode` stays 2.
